// File: rtl/mem_defs_pkg.sv
// mem_defs: shared definitions for the CPU data-memory bus.
//   state_t   - access sequencer states (IDLE, LO, HI, DONE)
//   SZ_*      - request size encoding carried on `size` and `memc`
//   *_BASE    - address map shared with the data memory
package mem_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic SZ_BYTE = 1'b0;
  localparam logic SZ_HALF = 1'b1;

  localparam logic [15:0] RAM_BASE   = 16'h1000;
  localparam logic [15:0] LED_BASE   = 16'h2000;
  localparam logic [15:0] DIGIT_BASE = 16'h3000;

endpackage

// File: rtl/mem_access_unit.sv
// mem_access_unit: CPU-side initiator for the data-memory bus.
// Takes one load/store at a time, drives wmem/DAddress/DataIn/memc, captures
// the memory's combinational DataOut and returns the load result. Misaligned
// halfwords are split into two byte accesses (low byte first). Stores below
// RAM_BASE are suppressed per byte and reported via `fault`.
//   CLK, RESET (async, active-low)
//   req/we/size/sign/addr/wdata  -> request from execute stage
//   ready, done, rdata, fault    -> handshake/result to execute stage
//   wmem, DAddress, DataIn, memc -> data memory bus; DataOut <- memory
module mem_access_unit
  import mem_defs::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req,
  input  logic        we,
  input  logic        size,
  input  logic        sign,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        ready,
  output logic        done,
  output logic [15:0] rdata,
  output logic        fault,
  output logic        wmem,
  output logic [15:0] DAddress,
  output logic [15:0] DataIn,
  output logic        memc,
  input  logic [15:0] DataOut
);

  state_t      r_state;
  logic        r_we;
  logic        r_size;
  logic        r_sign;
  logic        r_split;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata;
  logic [7:0]  r_lo;

  logic [15:0] w_addr_hi;
  logic        w_lo_ok;
  logic        w_hi_ok;

  function automatic logic [15:0] ext_byte(input logic [7:0] b, input logic s);
    return s ? {{8{b[7]}}, b} : {8'h00, b};
  endfunction

  // Second byte of a split access; wraps naturally at 16'hFFFF.
  assign w_addr_hi = r_addr + 16'd1;
  assign w_lo_ok   = (r_addr >= RAM_BASE);
  assign w_hi_ok   = (w_addr_hi >= RAM_BASE);

  assign ready = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign done  = (r_state == ST_DONE);
  assign rdata = r_rdata;
  // A split store faults if either byte lands below RAM.
  assign fault = done & r_we & (~w_lo_ok | (r_split & ~w_hi_ok));

  // Bus decodes only from registered state, never from the live request.
  always_comb begin
    wmem     = 1'b0;
    memc     = SZ_BYTE;
    DAddress = 16'h0000;
    DataIn   = 16'h0000;
    case (r_state)
      ST_LO: begin
        DAddress = r_addr;
        memc     = r_split ? SZ_BYTE : r_size;
        DataIn   = r_split ? {8'h00, r_wdata[7:0]} : r_wdata;
        wmem     = r_we & w_lo_ok;
      end
      ST_HI: begin
        DAddress = w_addr_hi;
        DataIn   = {8'h00, r_wdata[15:8]};
        wmem     = r_we & w_hi_ok;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      r_size  <= SZ_BYTE;
      r_sign  <= 1'b0;
      r_split <= 1'b0;
      r_addr  <= 16'h0000;
      r_wdata <= 16'h0000;
      r_rdata <= 16'h0000;
      r_lo    <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (req) begin
            r_we    <= we;
            r_size  <= size;
            r_sign  <= sign;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_split <= (size == SZ_HALF) & addr[0];
            r_state <= ST_LO;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_LO: begin
          if (r_split) begin
            r_lo    <= DataOut[7:0];
            r_state <= ST_HI;
          end else begin
            if (!r_we)
              r_rdata <= (r_size == SZ_HALF) ? DataOut : ext_byte(DataOut[7:0], r_sign);
            r_state <= ST_DONE;
          end
        end
        ST_HI: begin
          // Split accesses are always halfwords, assembled little-endian.
          if (!r_we)
            r_rdata <= {DataOut[7:0], r_lo};
          r_state <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-addressed memory model.
module tb_mem_access_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        req, we, size, sign;
  logic [15:0] addr, wdata;
  logic        ready, done, fault, wmem, memc;
  logic [15:0] rdata, DAddress, DataIn, DataOut;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  mem [0:65535];
  logic [15:0] w_nx;

  always #5 CLK = ~CLK;

  mem_access_unit dut (
    .CLK(CLK), .RESET(RESET), .req(req), .we(we), .size(size), .sign(sign),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .rdata(rdata),
    .fault(fault), .wmem(wmem), .DAddress(DAddress), .DataIn(DataIn),
    .memc(memc), .DataOut(DataOut)
  );

  // Little-endian data memory: combinational read, write on rising edge.
  assign w_nx    = DAddress + 16'd1;
  assign DataOut = memc ? {mem[w_nx], mem[DAddress]} : {8'h00, mem[DAddress]};
  always @(posedge CLK) begin
    if (wmem) begin
      mem[DAddress] <= DataIn[7:0];
      if (memc) mem[w_nx] <= DataIn[15:8];
    end
  end

  // Issue one request and observe it until done (bounded to 8 cycles).
  task automatic run_req(input logic i_we, input logic i_size, input logic i_sign,
                         input logic [15:0] i_addr, input logic [15:0] i_wdata,
                         output int done_cyc, output int n_wr,
                         output logic [15:0] rd, output logic flt, output logic wr_memc);
    done_cyc = -1; n_wr = 0; rd = 16'h0000; flt = 1'b0; wr_memc = 1'b0;
    @(negedge CLK);
    req = 1'b1; we = i_we; size = i_size; sign = i_sign; addr = i_addr; wdata = i_wdata;
    @(posedge CLK);
    @(negedge CLK);
    req = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (wmem) begin
        n_wr++;
        wr_memc = memc;
      end
      if (done) begin
        done_cyc = c;
        rd  = rdata;
        flt = fault;
        break;
      end
      @(negedge CLK);
    end
    $display("txn we=%0b size=%0b sign=%0b addr=%h wdata=%h -> done_cyc=%0d writes=%0d rdata=%h fault=%0b",
             i_we, i_size, i_sign, i_addr, i_wdata, done_cyc, n_wr, rd, flt);
  endtask

  task automatic test_reset();
    RESET = 1'b0; req = 1'b0; we = 1'b0; size = 1'b0; sign = 1'b0;
    addr = 16'h0000; wdata = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    repeat (2) @(negedge CLK);
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (rdata !== 16'h0000) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", rdata); end
    checks++; if ({fault, wmem, memc} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {fault, wmem, memc}); end
    checks++; if ({DAddress, DataIn} !== 32'h0) begin failures++; $display("FAIL reset_bus got=%h exp=00000000", {DAddress, DataIn}); end
    RESET = 1'b1;
    $display("txn reset released");
  endtask

  task automatic test_aligned();
    int dc, nw; logic [15:0] rd; logic fl, mc;
    run_req(1'b1, 1'b1, 1'b0, 16'h1004, 16'hBEEF, dc, nw, rd, fl, mc);
    checks++; if (nw !== 1) begin failures++; $display("FAIL aligned_st_writes got=%0d exp=1", nw); end
    checks++; if (mc !== 1'b1) begin failures++; $display("FAIL aligned_st_memc got=%b exp=1", mc); end
    checks++; if (dc !== 2) begin failures++; $display("FAIL aligned_st_latency got=%0d exp=2", dc); end
    checks++; if (fl !== 1'b0) begin failures++; $display("FAIL aligned_st_fault got=%b exp=0", fl); end
    checks++; if ({mem[16'h1005], mem[16'h1004]} !== 16'hBEEF) begin failures++; $display("FAIL aligned_st_mem got=%h exp=beef", {mem[16'h1005], mem[16'h1004]}); end
    run_req(1'b0, 1'b1, 1'b0, 16'h1004, 16'h0000, dc, nw, rd, fl, mc);
    checks++; if (rd !== 16'hBEEF) begin failures++; $display("FAIL aligned_ld_rdata got=%h exp=beef", rd); end
    checks++; if (dc !== 2) begin failures++; $display("FAIL aligned_ld_latency got=%0d exp=2", dc); end
    checks++; if (nw !== 0) begin failures++; $display("FAIL aligned_ld_writes got=%0d exp=0", nw); end
  endtask

  task automatic test_split();
    int dc, nw; logic [15:0] rd; logic fl, mc;
    run_req(1'b1, 1'b1, 1'b0, 16'h1007, 16'h1234, dc, nw, rd, fl, mc);
    checks++; if (nw !== 2) begin failures++; $display("FAIL split_st_writes got=%0d exp=2", nw); end
    checks++; if (mc !== 1'b0) begin failures++; $display("FAIL split_st_memc got=%b exp=0", mc); end
    checks++; if (dc !== 3) begin failures++; $display("FAIL split_st_latency got=%0d exp=3", dc); end
    checks++; if (mem[16'h1007] !== 8'h34) begin failures++; $display("FAIL split_st_lo got=%h exp=34", mem[16'h1007]); end
    checks++; if (mem[16'h1008] !== 8'h12) begin failures++; $display("FAIL split_st_hi got=%h exp=12", mem[16'h1008]); end
    run_req(1'b0, 1'b1, 1'b0, 16'h1007, 16'h0000, dc, nw, rd, fl, mc);
    checks++; if (rd !== 16'h1234) begin failures++; $display("FAIL split_ld_rdata got=%h exp=1234", rd); end
    checks++; if (dc !== 3) begin failures++; $display("FAIL split_ld_latency got=%0d exp=3", dc); end
  endtask

  task automatic test_byte_ext();
    int dc, nw; logic [15:0] rd; logic fl, mc;
    @(negedge CLK);
    mem[16'h1010] = 8'h85;
    mem[16'h1011] = 8'h7E;
    run_req(1'b0, 1'b0, 1'b1, 16'h1010, 16'h0000, dc, nw, rd, fl, mc);
    checks++; if (rd !== 16'hFF85) begin failures++; $display("FAIL byte_sext got=%h exp=ff85", rd); end
    checks++; if (dc !== 2) begin failures++; $display("FAIL byte_latency got=%0d exp=2", dc); end
    run_req(1'b0, 1'b0, 1'b0, 16'h1010, 16'h0000, dc, nw, rd, fl, mc);
    checks++; if (rd !== 16'h0085) begin failures++; $display("FAIL byte_zext got=%h exp=0085", rd); end
  endtask

  task automatic test_fault();
    int dc, nw; logic [15:0] rd; logic fl, mc;
    run_req(1'b1, 1'b1, 1'b0, 16'h0FFE, 16'hCAFE, dc, nw, rd, fl, mc);
    checks++; if (nw !== 0) begin failures++; $display("FAIL fault_st_writes got=%0d exp=0", nw); end
    checks++; if (fl !== 1'b1) begin failures++; $display("FAIL fault_st_fault got=%b exp=1", fl); end
    checks++; if (dc !== 2) begin failures++; $display("FAIL fault_st_latency got=%0d exp=2", dc); end
    checks++; if (rd !== 16'h0085) begin failures++; $display("FAIL fault_st_rdata_held got=%h exp=0085", rd); end
    @(negedge CLK);
    mem[16'h0FFF] = 8'h11;
    mem[16'h1000] = 8'h00;
    run_req(1'b1, 1'b1, 1'b0, 16'h0FFF, 16'h5AA5, dc, nw, rd, fl, mc);
    checks++; if (nw !== 1) begin failures++; $display("FAIL fault_split_writes got=%0d exp=1", nw); end
    checks++; if (fl !== 1'b1) begin failures++; $display("FAIL fault_split_fault got=%b exp=1", fl); end
    checks++; if (dc !== 3) begin failures++; $display("FAIL fault_split_latency got=%0d exp=3", dc); end
    checks++; if (mem[16'h1000] !== 8'h5A) begin failures++; $display("FAIL fault_split_hi got=%h exp=5a", mem[16'h1000]); end
    checks++; if (mem[16'h0FFF] !== 8'h11) begin failures++; $display("FAIL fault_split_lo got=%h exp=11", mem[16'h0FFF]); end
  endtask

  task automatic test_back_to_back();
    @(negedge CLK);
    req = 1'b1; we = 1'b0; size = 1'b1; sign = 1'b0; addr = 16'h1004; wdata = 16'h0000;
    @(posedge CLK);                      // cycle 0: first accepted
    @(negedge CLK);                      // cycle 1
    addr = 16'h1010; size = 1'b0;        // req still held
    checks++; if ({done, ready} !== 2'b00) begin failures++; $display("FAIL b2b_c1 got=%b exp=00", {done, ready}); end
    @(negedge CLK);                      // cycle 2
    checks++; if ({done, ready} !== 2'b11) begin failures++; $display("FAIL b2b_c2 got=%b exp=11", {done, ready}); end
    checks++; if (rdata !== 16'hBEEF) begin failures++; $display("FAIL b2b_rdata1 got=%h exp=beef", rdata); end
    @(negedge CLK);                      // cycle 3
    req = 1'b0;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_c3_done got=%b exp=0", done); end
    @(negedge CLK);                      // cycle 4
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_c4_done got=%b exp=1", done); end
    checks++; if (rdata !== 16'h0085) begin failures++; $display("FAIL b2b_rdata2 got=%h exp=0085", rdata); end
    $display("txn back-to-back loads 1004/1010 -> rdata=%h", rdata);
  endtask

  task automatic test_reset_abort();
    bit saw_done;
    @(negedge CLK);
    mem[16'h1001] = 8'h00;
    mem[16'h1002] = 8'h00;
    req = 1'b1; we = 1'b1; size = 1'b1; sign = 1'b0; addr = 16'h1001; wdata = 16'hABCD;
    @(posedge CLK);                      // cycle 0
    @(negedge CLK);                      // cycle 1: LO
    req = 1'b0;
    checks++; if (wmem !== 1'b1) begin failures++; $display("FAIL abort_lo_wmem got=%b exp=1", wmem); end
    @(negedge CLK);                      // cycle 2: HI
    checks++; if ({wmem, DAddress} !== {1'b1, 16'h1002}) begin failures++; $display("FAIL abort_hi_bus got=%h exp=11002", {wmem, DAddress}); end
    #1 RESET = 1'b0;
    #1;
    checks++; if (wmem !== 1'b0) begin failures++; $display("FAIL abort_wmem got=%b exp=0", wmem); end
    checks++; if ({ready, done, fault, memc} !== 4'b1000) begin failures++; $display("FAIL abort_flags got=%b exp=1000", {ready, done, fault, memc}); end
    checks++; if ({DAddress, DataIn, rdata} !== 48'h0) begin failures++; $display("FAIL abort_bus got=%h exp=0", {DAddress, DataIn, rdata}); end
    @(negedge CLK);
    RESET = 1'b1;
    checks++; if (mem[16'h1001] !== 8'hCD) begin failures++; $display("FAIL abort_lo_mem got=%h exp=cd", mem[16'h1001]); end
    checks++; if (mem[16'h1002] !== 8'h00) begin failures++; $display("FAIL abort_hi_mem got=%h exp=00", mem[16'h1002]); end
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (done) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL abort_no_done got=%b exp=0", saw_done); end
    $display("txn split store 1001 aborted in HI -> mem1001=%h mem1002=%h", mem[16'h1001], mem[16'h1002]);
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_split();
    test_byte_ext();
    test_fault();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
